// File: rtl/bep_frame_pkg.sv
// Frame layout, field widths and FSM encodings for the thermostat link.
// Shared by the transmitter and the receive path so both agree on the constants.
package bep_frame_pkg;

  localparam int ID_W       = 32;
  localparam int TEMP_W     = 16;
  localparam int STATE_W    = 8;
  localparam int TAIL_W     = 8;
  localparam int FRAME_BITS = 192;
  localparam int BIT_CNT_W  = 8;

  localparam logic [31:0]       PREAMBLE = 32'hAAAA_AAAA;
  localparam logic [15:0]       TYPE_1   = 16'h5A5A;
  localparam logic [15:0]       TYPE_2   = 16'hC3C3;
  localparam logic [31:0]       CONSTANT = 32'h0F0F_0F0F;
  localparam logic [TAIL_W-1:0] TAIL_1   = 8'hF0;
  localparam logic [TAIL_W-1:0] TAIL_2   = 8'h0F;
  localparam logic [TAIL_W-1:0] TAIL_3   = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } tx_state_e;

  // Packs the payload between the fixed header and tail, MSB transmitted first.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [ID_W-1:0]    id,
    input logic [TEMP_W-1:0]  room,
    input logic [TEMP_W-1:0]  setp,
    input logic [STATE_W-1:0] st
  );
    return {PREAMBLE, TYPE_1, TYPE_2, CONSTANT, id, room, setp, st,
            TAIL_1, TAIL_2, TAIL_3};
  endfunction

endpackage

// File: rtl/bep_manchester_tx_half_bit_timer.sv
// Half-bit timer: free-running down-counter that ticks on its last cycle.
// A synchronous clear restarts a full half-bit period.
module bep_half_bit_timer #(
  parameter int HALF_BIT_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = (HALF_BIT_CYCLES > 2) ? $clog2(HALF_BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HALF_BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clr_i || (cnt_q == '0)) cnt_d = RELOAD;
    else                        cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/bep_manchester_tx.sv
// Manchester (IEEE 802.3) transmitter for the 192-bit thermostat frame.
// Optional BEP_MANCHESTER_TX_REPEAT_EN: one start sends REPEAT_COUNT frames.
module bep_manchester_tx
  import bep_frame_pkg::*;
#(
  parameter int HALF_BIT_CYCLES = 8,
  parameter int GAP_BITS        = 4,
  parameter int REPEAT_COUNT    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ID_W-1:0]    thermostat_id,
  input  logic [TEMP_W-1:0]  room_temp,
  input  logic [TEMP_W-1:0]  set_temp,
  input  logic [STATE_W-1:0] state,
  output logic               tx_out,
  output logic               busy,
  output logic               done
);

`ifdef BEP_MANCHESTER_TX_REPEAT_EN
  localparam int FRAMES_PER_START = REPEAT_COUNT;
`else
  localparam int FRAMES_PER_START = 1;
`endif

  localparam int GAP_HALVES  = 2 * GAP_BITS;
  localparam int GAP_CNT_W   = (GAP_HALVES > 2) ? $clog2(GAP_HALVES) : 1;
  localparam int FRAME_CNT_W = (REPEAT_COUNT > 1) ? $clog2(REPEAT_COUNT + 1) : 1;
  localparam int MSB         = FRAME_BITS - 1;

  localparam logic [BIT_CNT_W-1:0]   LAST_BIT   = BIT_CNT_W'(FRAME_BITS - 1);
  localparam logic [GAP_CNT_W-1:0]   LAST_GAP   = GAP_CNT_W'(GAP_HALVES - 1);
  localparam logic [FRAME_CNT_W-1:0] LAST_FRAME = FRAME_CNT_W'(FRAMES_PER_START - 1);

  tx_state_e              state_q;
  logic                   tx_q, busy_q, done_q, phase_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [GAP_CNT_W-1:0]   gap_cnt_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic [FRAME_BITS-1:0]  sr_q;
  logic [FRAME_BITS-1:0]  frame_d;
  logic                   load, shift, tick, last_frame;

  assign frame_d    = build_frame(thermostat_id, room_temp, set_temp, state);
  assign load       = (state_q == ST_IDLE) && start;
  assign shift      = (state_q == ST_SEND) && tick && phase_q;
  assign last_frame = (frame_cnt_q == LAST_FRAME);

  bep_half_bit_timer #(
    .HALF_BIT_CYCLES(HALF_BIT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (load),
    .tick_o(tick)
  );

  // The register rotates rather than shifts, so after 192 bits it holds the
  // original frame again and repeated frames need no second payload copy.
  always_ff @(posedge clk) begin
    if (load)       sr_q <= frame_d;
    else if (shift) sr_q <= {sr_q[MSB-1:0], sr_q[MSB]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tx_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      phase_q     <= 1'b0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_SEND;
            busy_q      <= 1'b1;
            tx_q        <= ~frame_d[MSB];
            phase_q     <= 1'b0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            frame_cnt_q <= '0;
          end
        end
        // First half drives the inverted bit, second half the bit itself.
        ST_SEND: begin
          if (tick) begin
            if (!phase_q) begin
              phase_q <= 1'b1;
              tx_q    <= sr_q[MSB];
            end else begin
              phase_q <= 1'b0;
              if (bit_cnt_q == LAST_BIT) begin
                state_q   <= ST_GAP;
                tx_q      <= 1'b0;
                bit_cnt_q <= '0;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
                tx_q      <= ~sr_q[MSB-1];
              end
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (gap_cnt_q == LAST_GAP) begin
              gap_cnt_q <= '0;
              if (last_frame) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
                state_q     <= ST_SEND;
                tx_q        <= ~sr_q[MSB];
              end
            end else begin
              gap_cnt_q <= gap_cnt_q + 1'b1;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_bep_manchester_tx.sv
// Directed bench for bep_manchester_tx with HALF_BIT_CYCLES=2, GAP_BITS=4.
// Also covers the BEP_MANCHESTER_TX_REPEAT_EN build when that macro is defined.
module tb_bep_manchester_tx;

  localparam int HB = 2;
  localparam int GB = 4;
`ifdef BEP_MANCHESTER_TX_REPEAT_EN
  localparam int FPS = 3;
`else
  localparam int FPS = 1;
`endif
  localparam int BUSY_PER_FRAME = 784;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] thermostat_id;
  logic [15:0] room_temp, set_temp;
  logic [7:0]  state;
  logic        tx_out, busy, done;

  int checks = 0;
  int errors = 0;
  int busy_cyc = 0;
  int done_cyc = 0;

  typedef struct {
    logic [31:0]  id;
    logic [15:0]  rt;
    logic [15:0]  stt;
    logic [7:0]   st;
    logic [191:0] frame;
  } vec_t;

  vec_t vecs [3];

  bep_manchester_tx #(
    .HALF_BIT_CYCLES(HB),
    .GAP_BITS       (GB),
    .REPEAT_COUNT   (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .thermostat_id(thermostat_id),
    .room_temp    (room_temp),
    .set_temp     (set_temp),
    .state        (state),
    .tx_out       (tx_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
    if (done === 1'b1) done_cyc <= done_cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_payload(input int i);
    thermostat_id = vecs[i].id;
    room_temp     = vecs[i].rt;
    set_temp      = vecs[i].stt;
    state         = vecs[i].st;
  endtask

  task automatic snap(output int b, output int d);
    #1;
    b = busy_cyc;
    d = done_cyc;
  endtask

  // Entered on the falling edge of the first half-bit cycle; returns on the
  // falling edge of the cycle after the gap (or after DONE when last is set).
  task automatic decode(input bit last, input int dis_bit, input int sbit,
                        input int abort_bit, output logic [191:0] f);
    int   half_err, busy_err, gap_err;
    logic h0, h1;
    half_err = 0; busy_err = 0; gap_err = 0; f = '0; h0 = 1'b0; h1 = 1'b0;
    for (int b = 0; b < 192; b++) begin
      for (int c = 0; c < 2 * HB; c++) begin
        if (busy !== 1'b1 || done !== 1'b0) busy_err++;
        if (c == 0) h0 = tx_out;
        else if (c < HB) begin
          if (tx_out !== h0) half_err++;
        end else if (c == HB) h1 = tx_out;
        else if (tx_out !== h1) half_err++;
        if (b == dis_bit && c == 0) apply_payload(2);
        if (b == sbit) start = (c == 0);
        if (b == abort_bit && c == 0) begin
          #1 rst_n = 1'b0;
          #1;
          check_int("abort_tx_out", int'(tx_out), 0);
          check_int("abort_busy", int'(busy), 0);
          return;
        end
        @(negedge clk);
      end
      if (h0 === h1 || $isunknown(h1)) half_err++;
      f = {f[190:0], h1};
    end
    for (int c = 0; c < 2 * GB * HB; c++) begin
      if (tx_out !== 1'b0 || busy !== 1'b1 || done !== 1'b0) gap_err++;
      @(negedge clk);
    end
    check_int("midbit_transitions", half_err, 0);
    check_int("busy_during_send", busy_err, 0);
    check_int("gap_16_low_cycles", gap_err, 0);
    if (last) begin
      check_int("done_cycle", int'({done, busy, tx_out}), 4);
      @(negedge clk);
    end
  endtask

  initial begin
    int           b0, d0, b1, d1, nz;
    logic [191:0] f;

    vecs[0] = '{32'h1234_5678, 16'h00D2, 16'h00C8, 8'hA5,
                192'hAAAAAAAA_5A5AC3C3_0F0F0F0F_12345678_00D200C8_A5F00FFF};
    vecs[1] = '{32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 8'hFF,
                192'hAAAAAAAA_5A5AC3C3_0F0F0F0F_FFFFFFFF_FFFFFFFF_FFF00FFF};
    vecs[2] = '{32'h0000_0000, 16'h0000, 16'h0000, 8'h00,
                192'hAAAAAAAA_5A5AC3C3_0F0F0F0F_00000000_00000000_00F00FFF};

    rst_n = 1'b1;
    start = 1'b0;
    apply_payload(0);
    #3 rst_n = 1'b0;
    #1 check_int("reset_outputs", int'({tx_out, busy, done}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nz = 0;
    repeat (100) begin
      @(negedge clk);
      if ({tx_out, busy, done} !== 3'b000) nz++;
    end
    check_int("idle_after_reset", nz, 0);

    // Table-driven single-start transmissions
    for (int i = 0; i < 3; i++) begin
      apply_payload(i);
      @(negedge clk);
      snap(b0, d0);
      @(negedge clk);
      check_int("busy_before_start", int'(busy), 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int r = 0; r < FPS; r++) begin
        decode(r == FPS - 1, -1, -1, -1, f);
        check_vec("frame_vec", f, vecs[i].frame);
      end
      snap(b1, d1);
      check_int("busy_length", b1 - b0, FPS * BUSY_PER_FRAME);
      check_int("done_pulses", d1 - d0, 1);
    end

    // Payload stability with input changes and an ignored start mid-frame
    apply_payload(0);
    @(negedge clk);
    snap(b0, d0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    decode(FPS == 1, 40, 100, -1, f);
    check_vec("frame_stable", f, vecs[0].frame);
    for (int r = 1; r < FPS; r++) begin
      decode(r == FPS - 1, -1, -1, -1, f);
      check_vec("frame_stable_rep", f, vecs[0].frame);
    end
    repeat (20) @(negedge clk);
    snap(b1, d1);
    check_int("stable_done_pulses", d1 - d0, 1);
    check_int("stable_busy_length", b1 - b0, FPS * BUSY_PER_FRAME);

    // Reset mid-frame at bit 50, then a fresh frame with a new payload
    apply_payload(0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    decode(1'b0, -1, -1, 50, f);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_int("idle_after_abort", int'({tx_out, busy, done}), 0);
    apply_payload(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < FPS; r++) begin
      decode(r == FPS - 1, -1, -1, -1, f);
      check_vec("frame_after_abort", f, vecs[1].frame);
    end

    // Start held high: back-to-back frames decoded as the receive path would
    apply_payload(0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      for (int r = 0; r < FPS; r++) begin
        decode(r == FPS - 1, -1, -1, -1, f);
        check_vec("rx_header", {64'h0, f[191:96]}, {64'h0, 96'hAAAAAAAA_5A5AC3C3_0F0F0F0F});
        check_int("rx_tail", int'(f[23:0]), int'(24'hF00FFF));
        check_vec("rx_thermostat_id", {160'h0, f[95:64]}, {160'h0, vecs[s].id});
        check_int("rx_room_temp", int'(f[63:48]), int'(vecs[s].rt));
        check_int("rx_set_temp", int'(f[47:32]), int'(vecs[s].stt));
        check_int("rx_state", int'(f[31:24]), int'(vecs[s].st));
      end
      check_int("b2b_idle_cycle", int'({tx_out, busy, done}), 0);
      if (s < 2) apply_payload(s + 1);
      else start = 1'b0;
      @(negedge clk);
    end
    nz = 0;
    repeat (20) begin
      if ({tx_out, busy, done} !== 3'b000) nz++;
      @(negedge clk);
    end
    check_int("no_extra_frame", nz, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
